// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I control path: FSM states, ALU op codes,
// opcode values and datapath mux selects.
package ctrl_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd15;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] IMM_I      = 2'b00;
    localparam logic [1:0] IMM_S      = 2'b01;
    localparam logic [1:0] IMM_B      = 2'b10;
    localparam logic [1:0] IMM_J      = 2'b11;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder shared with the single-cycle core: maps the
// operation class and funct fields to an ALU code, flagging funct3 values we do not implement.
import ctrl_pkg::*;

module alu_decoder #(
    parameter int ALUCTRL_W     = 4,
    parameter bit ENABLE_SHIFTS = 1'b1
) (
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  alu_op_t              alu_op,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic                 unsupported
);

    logic [3:0] funct_code;
    logic [3:0] code;

    // unsupported depends only on the funct fields so DECODE can trap early
    always_comb begin
        funct_code  = ALU_ADD;
        unsupported = 1'b0;
        case (funct3)
            3'b000: funct_code = (op == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001: begin
                funct_code  = ALU_SLL;
                unsupported = !ENABLE_SHIFTS;
            end
            3'b010: funct_code = ALU_SLT;
            3'b011: unsupported = 1'b1;
            3'b100: funct_code = ALU_XOR;
            3'b101: begin
                funct_code  = funct7b5 ? ALU_SRA : ALU_SRL;
                unsupported = !ENABLE_SHIFTS;
            end
            3'b110: funct_code = ALU_OR;
            3'b111: funct_code = ALU_AND;
            default: funct_code = ALU_ADD;
        endcase
    end

    always_comb begin
        code = ALU_ADD;
        case (alu_op)
            ALUOP_SUB:   code = ALU_SUB;
            ALUOP_FUNCT: code = funct_code;
            default:     code = ALU_ADD;
        endcase
    end

    assign alu_control = ALUCTRL_W'(code);

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle RV32I datapath with a shared
// instruction/data memory driven through a req/ready handshake.
import ctrl_pkg::*;

module multicycle_control_unit #(
    parameter int ALUCTRL_W     = 4,
    parameter bit ENABLE_SHIFTS = 1'b1,
    parameter bit ENABLE_JAL    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instr,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           result_src,
    output logic [1:0]           imm_src,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic                 illegal,
    output logic [3:0]           state_dbg
);

    logic [3:0] state, state_next;
    logic [6:0] op;
    alu_op_t    alu_op;
    logic       unsupported;
    logic       req, wr, irw, pcw, rgw;
    logic       unused_instr_bits;

    assign op                = instr[6:0];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    alu_decoder #(
        .ALUCTRL_W    (ALUCTRL_W),
        .ENABLE_SHIFTS(ENABLE_SHIFTS)
    ) u_alu_decoder (
        .op         (op),
        .funct3     (instr[14:12]),
        .funct7b5   (instr[30]),
        .alu_op     (alu_op),
        .alu_control(alu_control),
        .unsupported(unsupported)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = unsupported ? S_TRAP : S_EXECUTER;
                    OP_ITYPE:          state_next = unsupported ? S_TRAP : S_EXECUTEI;
                    OP_BRANCH:         state_next = S_BEQ;
                    OP_JAL:            state_next = ENABLE_JAL ? S_JAL : S_TRAP;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEMADR:   state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
            S_EXECUTER, S_EXECUTEI: state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            default:    state_next = S_TRAP;
        endcase
    end

    // illegal is set on the edge that enters TRAP and only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next == S_TRAP) illegal <= 1'b1;
        end
    end

    always_comb begin
        req        = 1'b0;
        wr         = 1'b0;
        irw        = 1'b0;
        pcw        = 1'b0;
        rgw        = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUOUT;
        imm_src    = IMM_I;
        alu_op     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                req        = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                irw        = mem_ready;
                pcw        = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_B;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                req     = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                rgw        = 1'b1;
            end
            S_MEMWRITE: begin
                req     = 1'b1;
                wr      = 1'b1;
                adr_src = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: rgw = 1'b1;
            S_BEQ: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_SUB;
                pcw       = zero;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                imm_src   = IMM_J;
                pcw       = 1'b1;
            end
            default: ;
        endcase
    end

    // strobes are forced low while reset is held so an in-flight access is abandoned at once
    assign mem_req   = req & rst_n;
    assign mem_write = wr & rst_n;
    assign ir_write  = irw & rst_n;
    assign pc_write  = pcw & rst_n;
    assign reg_write = rgw & rst_n;
    assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: table-driven instruction
// walks plus hand sequences for memory waits, traps and asynchronous reset.
module tb_multicycle_control_unit;

    localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2,
                           ST_MEMREAD = 4'd3, ST_MEMWB = 4'd4, ST_MEMWRITE = 4'd5,
                           ST_EXECR = 4'd6, ST_EXECI = 4'd7, ST_ALUWB = 4'd8,
                           ST_BEQ = 4'd9, ST_JAL = 4'd10, ST_TRAP = 4'd15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, result_src, imm_src;
    logic [3:0]  alu_control;
    logic        illegal;
    logic [3:0]  state_dbg;

    int compared = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
        logic [1:0] a, b, rs, imm;
        logic       illegal;
    } obs_t;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        int          len;
        logic [3:0]  states [5];
        logic [3:0]  alu;
        string       name;
    } vec_t;

    vec_t       vecs [$];
    obs_t       expQ [$];
    logic [3:0] aluQ [$];

    multicycle_control_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .imm_src    (imm_src),
        .alu_control(alu_control),
        .illegal    (illegal),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    // expected outputs for a state, taken from the control table of the datapath
    function automatic obs_t model(input logic [3:0] st, input logic [31:0] ins,
                                   input logic z, input logic rdy);
        obs_t o;
        o = '0;
        o.st = st;
        o.illegal = (st == ST_TRAP);
        case (st)
            ST_FETCH: begin
                o.mem_req = 1'b1; o.b = 2'b10; o.rs = 2'b10;
                o.ir_write = rdy; o.pc_write = rdy;
            end
            ST_DECODE:   begin o.a = 2'b01; o.b = 2'b01; o.imm = 2'b10; end
            ST_MEMADR:   begin o.a = 2'b10; o.b = 2'b01;
                               o.imm = (ins[6:0] == 7'b0100011) ? 2'b01 : 2'b00; end
            ST_MEMREAD:  begin o.mem_req = 1'b1; o.adr_src = 1'b1; end
            ST_MEMWB:    begin o.rs = 2'b01; o.reg_write = 1'b1; end
            ST_MEMWRITE: begin o.mem_req = 1'b1; o.mem_write = 1'b1; o.adr_src = 1'b1; end
            ST_EXECR:    begin o.a = 2'b10; end
            ST_EXECI:    begin o.a = 2'b10; o.b = 2'b01; end
            ST_ALUWB:    begin o.reg_write = 1'b1; end
            ST_BEQ:      begin o.a = 2'b10; o.pc_write = z; end
            ST_JAL:      begin o.a = 2'b01; o.b = 2'b10; o.imm = 2'b11; o.pc_write = 1'b1; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic void addVec(input logic [31:0] ins, input logic z, input int len,
                                   input logic [3:0] s0, input logic [3:0] s1,
                                   input logic [3:0] s2, input logic [3:0] s3,
                                   input logic [3:0] s4, input logic [3:0] alu,
                                   input string name);
        vec_t v;
        v.instr = ins; v.zero = z; v.len = len; v.alu = alu; v.name = name;
        v.states[0] = s0; v.states[1] = s1; v.states[2] = s2;
        v.states[3] = s3; v.states[4] = s4;
        vecs.push_back(v);
    endfunction

    function automatic void compareVal(input string name, input logic [31:0] got,
                                       input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h want %h", name, got, want);
        end
    endfunction

    task automatic checkOutput(input string tag);
        obs_t       act, exp;
        logic [3:0] expAlu;
        act = '{state_dbg, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, result_src, imm_src, illegal};
        exp    = expQ.pop_front();
        expAlu = aluQ.pop_front();
        compareVal({tag, " ctrl"}, 32'(act), 32'(exp));
        compareVal({tag, " alu"}, 32'(alu_control), 32'(expAlu));
    endtask

    // drive one cycle, queue its expectation, compare away from the rising edge
    task automatic applyStimulus(input logic [31:0] ins, input logic z, input logic rdy,
                                 input logic [3:0] expSt, input logic [3:0] expAlu,
                                 input string tag);
        instr = ins; zero = z; mem_ready = rdy;
        expQ.push_back(model(expSt, ins, z, rdy));
        aluQ.push_back(expAlu);
        @(negedge clk);
        checkOutput(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        addVec(32'h002081B3, 1'b0, 4, ST_FETCH, ST_DECODE, ST_EXECR, ST_ALUWB, ST_FETCH, 4'b0000, "add");
        addVec(32'h402081B3, 1'b0, 4, ST_FETCH, ST_DECODE, ST_EXECR, ST_ALUWB, ST_FETCH, 4'b0001, "sub");
        addVec(32'h0020C1B3, 1'b0, 4, ST_FETCH, ST_DECODE, ST_EXECR, ST_ALUWB, ST_FETCH, 4'b0100, "xor");
        addVec(32'h0020A1B3, 1'b0, 4, ST_FETCH, ST_DECODE, ST_EXECR, ST_ALUWB, ST_FETCH, 4'b0101, "slt");
        addVec(32'h0020F1B3, 1'b0, 4, ST_FETCH, ST_DECODE, ST_EXECR, ST_ALUWB, ST_FETCH, 4'b0010, "and");
        addVec(32'h0020E1B3, 1'b0, 4, ST_FETCH, ST_DECODE, ST_EXECR, ST_ALUWB, ST_FETCH, 4'b0011, "or");
        addVec(32'h4020D1B3, 1'b0, 4, ST_FETCH, ST_DECODE, ST_EXECR, ST_ALUWB, ST_FETCH, 4'b1000, "sra");
        addVec(32'h4030D093, 1'b0, 4, ST_FETCH, ST_DECODE, ST_EXECI, ST_ALUWB, ST_FETCH, 4'b1000, "srai");
        addVec(32'h0030D093, 1'b0, 4, ST_FETCH, ST_DECODE, ST_EXECI, ST_ALUWB, ST_FETCH, 4'b0111, "srli");
        addVec(32'h00309093, 1'b0, 4, ST_FETCH, ST_DECODE, ST_EXECI, ST_ALUWB, ST_FETCH, 4'b0110, "slli");
        addVec(32'h40008093, 1'b0, 4, ST_FETCH, ST_DECODE, ST_EXECI, ST_ALUWB, ST_FETCH, 4'b0000, "addi_b30");
        addVec(32'h0040A183, 1'b0, 5, ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMREAD, ST_MEMWB, 4'b0000, "lw");
        addVec(32'h0020A223, 1'b0, 4, ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMWRITE, ST_FETCH, 4'b0000, "sw");
        addVec(32'h00208463, 1'b1, 3, ST_FETCH, ST_DECODE, ST_BEQ, ST_FETCH, ST_FETCH, 4'b0001, "beq_taken");
        addVec(32'h00208463, 1'b0, 3, ST_FETCH, ST_DECODE, ST_BEQ, ST_FETCH, ST_FETCH, 4'b0001, "beq_not");
        addVec(32'h008000EF, 1'b0, 4, ST_FETCH, ST_DECODE, ST_JAL, ST_ALUWB, ST_FETCH, 4'b0000, "jal");

        rst_n = 1'b0; instr = '0; zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        compareVal("reset state", 32'(state_dbg), 32'(ST_FETCH));
        compareVal("reset illegal", 32'(illegal), 32'd0);
        compareVal("reset mem_req", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[k]) begin
            for (int i = 0; i < vecs[k].len; i++) begin
                applyStimulus(vecs[k].instr, vecs[k].zero, 1'b1, vecs[k].states[i],
                              (i == 2) ? vecs[k].alu : 4'b0000,
                              $sformatf("%s c%0d", vecs[k].name, i));
            end
        end

        // fetch stall, then lw with three wait cycles in MEMREAD (8 cycles total)
        applyStimulus(32'h0040A183, 1'b0, 1'b0, ST_FETCH, 4'b0000, "fetch_stall0");
        applyStimulus(32'h0040A183, 1'b0, 1'b0, ST_FETCH, 4'b0000, "fetch_stall1");
        applyStimulus(32'h0040A183, 1'b0, 1'b1, ST_FETCH, 4'b0000, "lww c0");
        applyStimulus(32'h0040A183, 1'b0, 1'b1, ST_DECODE, 4'b0000, "lww c1");
        applyStimulus(32'h0040A183, 1'b0, 1'b1, ST_MEMADR, 4'b0000, "lww c2");
        for (int w = 0; w < 3; w++)
            applyStimulus(32'h0040A183, 1'b0, 1'b0, ST_MEMREAD, 4'b0000, $sformatf("lww wait%0d", w));
        applyStimulus(32'h0040A183, 1'b0, 1'b1, ST_MEMREAD, 4'b0000, "lww done");
        applyStimulus(32'h0040A183, 1'b0, 1'b1, ST_MEMWB, 4'b0000, "lww wb");

        // unsupported sltu traps straight from DECODE
        applyStimulus(32'h0020B1B3, 1'b0, 1'b1, ST_FETCH, 4'b0000, "sltu c0");
        applyStimulus(32'h0020B1B3, 1'b0, 1'b1, ST_DECODE, 4'b0000, "sltu c1");
        applyStimulus(32'h0020B1B3, 1'b0, 1'b1, ST_TRAP, 4'b0000, "sltu trap");
        rst_n = 1'b0;
        #1;
        compareVal("sltu reset state", 32'(state_dbg), 32'(ST_FETCH));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // illegal opcode: trap is sticky until reset
        applyStimulus(32'h0000007F, 1'b0, 1'b1, ST_FETCH, 4'b0000, "ill c0");
        applyStimulus(32'h0000007F, 1'b0, 1'b1, ST_DECODE, 4'b0000, "ill c1");
        for (int t = 0; t < 3; t++)
            applyStimulus(32'h0000007F, 1'b0, 1'b1, ST_TRAP, 4'b0000, $sformatf("ill hold%0d", t));
        rst_n = 1'b0;
        #1;
        compareVal("ill reset state", 32'(state_dbg), 32'(ST_FETCH));
        compareVal("ill reset illegal", 32'(illegal), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // reset asserted while a store is waiting on memory
        applyStimulus(32'h0020A223, 1'b0, 1'b1, ST_FETCH, 4'b0000, "swr c0");
        applyStimulus(32'h0020A223, 1'b0, 1'b1, ST_DECODE, 4'b0000, "swr c1");
        applyStimulus(32'h0020A223, 1'b0, 1'b1, ST_MEMADR, 4'b0000, "swr c2");
        applyStimulus(32'h0020A223, 1'b0, 1'b0, ST_MEMWRITE, 4'b0000, "swr wait");
        rst_n = 1'b0;
        #1;
        compareVal("swr rst mem_req", 32'(mem_req), 32'd0);
        compareVal("swr rst mem_write", 32'(mem_write), 32'd0);
        compareVal("swr rst state", 32'(state_dbg), 32'(ST_FETCH));
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(32'h002081B3, 1'b0, 1'b1, ST_FETCH, 4'b0000, "after rst c0");
        applyStimulus(32'h002081B3, 1'b0, 1'b1, ST_DECODE, 4'b0000, "after rst c1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore-style control FSM for the multicycle RV32I datapath; next generation of the single-cycle control decoder.
- Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK over several cycles.
- Drives one shared instruction/data memory through a req/ready handshake.
- Adds ALU ops (xor, slt, shifts), jal and illegal-opcode trapping.
- Sits between the instruction register and the shared-memory datapath (PC, ALUOut, Data registers).

Parameters:
- ALUCTRL_W, 4, width of alu_control; must be >= 4.
- ENABLE_SHIFTS, 1, 1 = decode sll/srl/sra/slli/srli/srai; 0 = these opcodes raise illegal.
- ENABLE_JAL, 1, 1 = decode jal (op 1101111); 0 = illegal.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  32  instruction register contents; valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request; held until mem_ready.
- mem_write  out  1  access is a store; valid only with mem_req.
- adr_src  out  1  0 = PC, 1 = ALUOut as memory address.
- ir_write  out  1  load instruction register.
- pc_write  out  1  load PC from result bus.
- reg_write  out  1  register file write enable.
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALU result (direct).
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J.
- alu_control  out  ALUCTRL_W  encoding below.
- illegal  out  1  sticky trap flag.
- state_dbg  out  4  current state encoding.

Behaviour:
- States (4-bit): FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=15.
- Reset (async, rst_n=0): state=FETCH, illegal=0. All outputs are combinational from state/instr/zero/mem_ready; unlisted outputs are 0 in each state.
- FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_control=add, result_src=10. ir_write and pc_write are asserted only in the cycle mem_ready=1, then go to DECODE; otherwise stay in FETCH.
- DECODE (1 cycle): a=01, b=01, imm_src=10, add; computes the branch target into ALUOut. Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL if ENABLE_JAL
  - anything else -> TRAP
- MEMADR: a=10, b=01, add; imm_src=01 for sw, else 00. Go to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_req=1, adr_src=1; stay until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1; stay until mem_ready, then FETCH.
- EXECUTER: a=10, b=00, alu_control from funct3/funct7 -> ALUWB.
- EXECUTEI: a=10, b=01, imm_src=00, alu_control from funct3 -> ALUWB.
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- BEQ: a=10, b=00, sub, result_src=00; pc_write=zero -> FETCH.
- JAL: a=01, b=10, add, imm_src=11, result_src=00, pc_write=1 -> ALUWB (writes PC+4 to rd).
- TRAP: all strobes 0, illegal=1 (registered on entry); stays until reset.
- ALU encoding: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sll 0110, srl 0111, sra 1000.
- funct decode:
  - sub only when R-type and funct7[5]=1; addi ignores instr[30].
  - funct3=101: funct7[5] selects sra/srl for both R- and I-type.
  - Shifts with ENABLE_SHIFTS=0 -> TRAP.
  - Unsupported funct3 (010/011 other than slt, i.e. sltu) -> TRAP.
- Handshake: mem_req must not drop until mem_ready. mem_ready while mem_req=0 is ignored. Each access completes in ≥1 cycle.
- Reset mid-access: mem_req drops immediately; the memory must discard the access.
- CPI: R/I-type 4, lw 5, sw 4, beq 3, jal 4, each with zero-wait memory.

Decomposition:
- Package ctrl_pkg: state encodings, ALU op codes, opcode constants, mux-select constants.
- One sub-module, alu_decoder: combinational (op, funct3, funct7[5], alu_op class) -> alu_control plus an unsupported flag. It is reused by the single-cycle core.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready=1 always -> states 0,1,6,8,0; reg_write=1 only in ALUWB; alu_control=0000 in EXECUTER.
- lw (0x0040A183) with mem_ready delayed 3 cycles in MEMREAD -> mem_req held 3 cycles with adr_src=1; MEMWB result_src=01, reg_write=1; total 8 cycles.
- beq with zero=1, then zero=0 -> pc_write 1 / 0 in BEQ; alu_control=0001.
- srai (0x4030D093) -> alu_control=1000; addi with instr[30]=1 -> 0000 (not sub).
- Opcode 0x0000007F -> TRAP after DECODE; illegal=1 held; rst_n low -> FETCH, illegal=0.
- rst_n asserted mid-MEMWRITE -> mem_req and mem_write drop the same cycle (async); FETCH after release.
